// File: rtl/riscv_dmem_responder.sv
// riscv_dmem_responder: memory-side responder for the datapath's load/store
// port. It takes one request at a time, waits WAIT_CYCLES, then commits the
// store or extracts the load lanes and holds the response until it is taken.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready.
// A response transfers on a rising edge where rsp_valid && rsp_ready. req_ready
// is high only in IDLE and rsp_valid only in RESP, so a request is never
// accepted in the same cycle that a response is consumed.
module riscv_dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // FSM state is a named, bindable signal for assertions and debug probes.
  state_t      state;
  state_t      state_next;
  logic [3:0]  cnt;
  logic [3:0]  cnt_next;
  logic        accept;
  logic        commit;

  // Latched request fields.
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [1:0]  lat_size;
  logic        lat_unsigned;
  logic [31:0] lat_wdata;

  // Request the commit acts on. With zero wait states the commit happens on
  // the accept edge itself, so the live inputs are used instead of the latch.
  logic        cur_we;
  logic [31:0] cur_addr;
  logic [1:0]  cur_size;
  logic        cur_unsigned;
  logic [31:0] cur_wdata;

  // Decode results.
  logic             misaligned;
  logic             illegal_size;
  logic             in_range;
  logic             err;
  logic [IDX_W-1:0] idx;
  logic [31:0]      rd_word;
  logic [7:0]       rd_byte;
  logic [15:0]      rd_half;
  logic [31:0]      load_data;
  logic [3:0]       byte_en;
  logic [31:0]      wr_data;

  logic [31:0] mem [DEPTH_WORDS];

  // State register and wait counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic, handshake outputs and the accept/commit strobes.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    accept     = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            commit     = 1'b1;
            state_next = RESP;
          end else begin
            cnt_next   = WAIT_INIT;
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        // The edge seen while the counter holds 1 is the commit edge.
        if (cnt <= 4'd1) begin
          commit     = 1'b1;
          cnt_next   = 4'd0;
          state_next = RESP;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  // Capture every request field on the accept edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      lat_we       <= 1'b0;
      lat_addr     <= 32'd0;
      lat_size     <= 2'd0;
      lat_unsigned <= 1'b0;
      lat_wdata    <= 32'd0;
    end else if (accept) begin
      lat_we       <= req_we;
      lat_addr     <= req_addr;
      lat_size     <= req_size;
      lat_unsigned <= req_unsigned;
      lat_wdata    <= req_wdata;
    end
  end

  // Select the request source for the commit edge.
  always_comb begin
    if (WAIT_CYCLES == 0) begin
      cur_we       = req_we;
      cur_addr     = req_addr;
      cur_size     = req_size;
      cur_unsigned = req_unsigned;
      cur_wdata    = req_wdata;
    end else begin
      cur_we       = lat_we;
      cur_addr     = lat_addr;
      cur_size     = lat_size;
      cur_unsigned = lat_unsigned;
      cur_wdata    = lat_wdata;
    end
  end

  // Error classification and word index.
  always_comb begin
    illegal_size = (cur_size == 2'b11);
    misaligned   = ((cur_size == 2'b01) && cur_addr[0]) ||
                   ((cur_size == 2'b10) && (cur_addr[1:0] != 2'b00));
    in_range     = ({2'b00, cur_addr[31:2]} < 32'(DEPTH_WORDS));
    err          = illegal_size || misaligned || !in_range;
    idx          = cur_addr[IDX_W+1:2];
  end

  // Load lane extraction with sign or zero extension.
  always_comb begin
    rd_word   = mem[idx];
    rd_byte   = rd_word[{cur_addr[1:0], 3'b000} +: 8];
    rd_half   = cur_addr[1] ? rd_word[31:16] : rd_word[15:0];
    load_data = 32'd0;
    case (cur_size)
      2'b00:   load_data = cur_unsigned ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      2'b01:   load_data = cur_unsigned ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
      2'b10:   load_data = rd_word;
      default: load_data = 32'd0;
    endcase
  end

  // Store lane enables; data is replicated so every enabled lane sees it.
  always_comb begin
    byte_en = 4'b0000;
    wr_data = cur_wdata;
    case (cur_size)
      2'b00: begin
        byte_en = 4'b0001 << cur_addr[1:0];
        wr_data = {4{cur_wdata[7:0]}};
      end
      2'b01: begin
        byte_en = cur_addr[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{cur_wdata[15:0]}};
      end
      2'b10: begin
        byte_en = 4'b1111;
        wr_data = cur_wdata;
      end
      default: begin
        byte_en = 4'b0000;
        wr_data = cur_wdata;
      end
    endcase
  end

  // Array write on the commit edge; reset or an error suppresses it.
  always_ff @(posedge clock) begin
    if (!reset && commit && cur_we && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) begin
          mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  // Response registers, loaded on the commit edge and held through RESP.
  always_ff @(posedge clock) begin
    if (reset) begin
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else if (commit) begin
      rsp_err   <= err;
      rsp_rdata <= (err || cur_we) ? 32'd0 : load_data;
    end
  end

endmodule
